// File: rtl/usb_desc_server.sv
// usb_desc_server: serves GET_DESCRIPTOR requests as a byte stream with wLength truncation,
// speed-dependent endpoint patching and stall on unsupported requests.
module usb_desc_server #(
  parameter logic [15:0]     VENDORID       = 16'h33AA,
  parameter logic [15:0]     PRODUCTID      = 16'h0000,
  parameter logic [15:0]     VERSIONBCD     = 16'h0100,
  parameter int              NUM_EP         = 1,
  parameter logic [3:0]      EP_DIR_MASK    = 4'b0001,
  parameter bit              HSSUPPORT      = 1'b1,
  parameter bit              SELFPOWERED    = 1'b1,
  parameter logic [8*64-1:0] VENDORSTR      = "OV5640 Camera",
  parameter int              VENDORSTR_LEN  = 13,
  parameter logic [8*64-1:0] PRODUCTSTR     = "Video Streamer",
  parameter int              PRODUCTSTR_LEN = 14,
  parameter logic [8*64-1:0] SERIALSTR      = "12345678",
  parameter int              SERIALSTR_LEN  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] i_vid,
  input  logic [15:0] i_pid,
  input  logic        i_hs_mode,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_type,
  input  logic [7:0]  i_req_index,
  input  logic [15:0] i_req_wlength,
  input  logic        i_abort,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last,
  output logic        o_done,
  output logic        o_stall
);
  typedef enum logic [1:0] {IDLE, LOOKUP, STREAM, DONE} state_t;
  localparam logic [15:0] CFG_LEN = 16'(18 + 7 * NUM_EP);
  state_t state_q;
  logic [7:0] type_q, idx_q;
  logic [15:0] wlen_q, vid_q, pid_q, ptr_q, cnt;
  logic hs_q, bad, ehs;
  logic [7:0] len, b, off, slen, so, ci, eo, ep, ej, addr, epb;
  logic [8*64-1:0] str, sc;
  logic [17:0][7:0] dev, cfg;
  logic [11:0][7:0] bos;
  logic [9:0][7:0] qual;
  logic [3:0][7:0] lang;
  always_comb begin
    off  = ptr_q[7:0];
    str  = idx_q == 8'd1 ? VENDORSTR : idx_q == 8'd2 ? PRODUCTSTR : SERIALSTR;
    slen = idx_q == 8'd1 ? 8'(VENDORSTR_LEN) : idx_q == 8'd2 ? 8'(PRODUCTSTR_LEN) :
           idx_q == 8'd3 ? 8'(SERIALSTR_LEN) : 8'd0;
    so   = off - 8'd2;
    ci   = {1'b0, so[7:1]};
    // strings are right-aligned in the parameter, so character 0 sits highest
    sc   = str >> {slen - ci - 8'd1, 3'b000};
    ehs  = type_q == 8'd7 ? !hs_q : hs_q;
    eo   = off - 8'd18;
    ep   = eo / 8'd7;
    ej   = eo % 8'd7;
    addr = {EP_DIR_MASK[ep[1:0]], 4'b0000, ep[2:0] + 3'd1};
    epb  = ej == 8'd0 ? 8'h07 : ej == 8'd1 ? 8'h05 : ej == 8'd2 ? addr : ej == 8'd3 ? 8'h02 :
           ej == 8'd4 ? (ehs ? 8'h00 : 8'h40) : ej == 8'd5 ? (ehs ? 8'h02 : 8'h00) : 8'h00;
    dev  = {8'h01, SERIALSTR_LEN != 0 ? 8'h03 : 8'h00, PRODUCTSTR_LEN != 0 ? 8'h02 : 8'h00,
            VENDORSTR_LEN != 0 ? 8'h01 : 8'h00, VERSIONBCD[15:8], VERSIONBCD[7:0],
            pid_q[15:8], pid_q[7:0], vid_q[15:8], vid_q[7:0],
            8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h12};
    cfg  = {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'(NUM_EP), 8'h00, 8'h00, 8'h04, 8'h09,
            8'h32, SELFPOWERED ? 8'hC0 : 8'h80, 8'h00, 8'h01, 8'h01,
            CFG_LEN[15:8], CFG_LEN[7:0], type_q == 8'd7 ? 8'h07 : 8'h02, 8'h09};
    qual = {8'h00, 8'h01, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h06, 8'h0A};
    bos  = {8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h10, 8'h07, 8'h01, 8'h00, 8'h0C, 8'h0F, 8'h05};
    lang = {8'h04, 8'h09, 8'h03, 8'h04};
    bad  = 1'b0;
    len  = 8'd0;
    case (type_q)
      8'd1:    begin len = 8'd18;         bad = idx_q != 8'd0; end
      8'd2:    begin len = CFG_LEN[7:0];  bad = idx_q != 8'd0; end
      8'd6:    begin len = 8'd10;         bad = idx_q != 8'd0 || !HSSUPPORT; end
      8'd7:    begin len = CFG_LEN[7:0];  bad = idx_q != 8'd0 || !HSSUPPORT; end
      8'd15:   begin len = 8'd12;         bad = idx_q != 8'd0; end
      8'd3:    begin len = idx_q == 8'd0 ? 8'd4 : 8'd2 + {slen[6:0], 1'b0}; bad = idx_q != 8'd0 && slen == 8'd0; end
      default: bad = 1'b1;
    endcase
    b = type_q == 8'd1 ? dev[off[4:0]] :
        type_q == 8'd6 ? qual[off[3:0]] :
        type_q == 8'd15 ? bos[off[3:0]] :
        type_q == 8'd3 ? (idx_q == 8'd0 ? lang[off[1:0]] : off == 8'd0 ? len : off == 8'd1 ? 8'h03 :
                          so[0] ? 8'h00 : sc[7:0]) :
        off < 8'd18 ? cfg[off[4:0]] : epb;
    cnt = wlen_q < {8'h00, len} ? wlen_q : {8'h00, len};
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      o_req_ready <= 1'b1;
      {o_valid, o_last, o_done, o_stall} <= '0;
      o_data <= '0;
      {type_q, idx_q, wlen_q, vid_q, pid_q, ptr_q, hs_q} <= '0;
    end else if (i_abort) begin
      state_q <= IDLE;
      o_req_ready <= 1'b1;
      {o_valid, o_last, o_done, o_stall} <= '0;
    end else
      case (state_q)
        IDLE: begin
          o_done  <= 1'b0;
          o_stall <= 1'b0;
          if (i_req_valid) begin
            type_q <= i_req_type;
            idx_q  <= i_req_index;
            wlen_q <= i_req_wlength;
            hs_q   <= i_hs_mode;
            vid_q  <= i_vid == 16'h0000 || i_vid == 16'hFFFF ? VENDORID : i_vid;
            pid_q  <= i_pid == 16'h0000 || i_pid == 16'hFFFF ? PRODUCTID : i_pid;
            ptr_q  <= '0;
            o_req_ready <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP:
          if (bad) begin
            o_stall <= 1'b1;
            o_req_ready <= 1'b1;
            state_q <= IDLE;
          end else if (cnt == 16'd0) begin
            o_done  <= 1'b1;
            state_q <= DONE;
          end else begin
            o_valid <= 1'b1;
            o_data  <= b;
            o_last  <= cnt == 16'd1;
            ptr_q   <= 16'd1;
            state_q <= STREAM;
          end
        STREAM:
          if (i_ready) begin
            if (o_last) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_done  <= 1'b1;
              state_q <= DONE;
            end else begin
              o_data <= b;
              o_last <= ptr_q == cnt - 16'd1;
              ptr_q  <= ptr_q + 16'd1;
            end
          end
        default: begin
          o_done <= 1'b0;
          o_req_ready <= 1'b1;
          state_q <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_usb_desc_server.sv
// tb_usb_desc_server: descriptor-level model with a per-cycle stream checker and directed requests.
module tb_usb_desc_server;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [15:0] i_vid = '0, i_pid = '0, i_req_wlength = '0;
  logic i_hs_mode = 1'b1, i_req_valid = 1'b0, i_abort = 1'b0, i_ready = 1'b1;
  logic [7:0] i_req_type = '0, i_req_index = '0;
  logic [7:0] o_data, d1;
  logic o_req_ready, o_valid, o_last, o_done, o_stall;
  logic r1, v1, l1, dn1, st1;
  int n_chk = 0, n_fail = 0, done_cnt = 0, stall_cnt = 0, stall1_cnt = 0;
  bit v1_seen = 0, held_v = 0, rnd_ready = 0, hold_rdy = 0, exp_st = 0;
  logic [7:0] held_d, e;
  logic held_l;
  logic [7:0] exp_q[$], rx[$], desc[$];

  usb_desc_server #(.NUM_EP(3), .EP_DIR_MASK(4'b0101)) dut (
    .CLK(CLK), .RESET(RESET), .i_vid(i_vid), .i_pid(i_pid), .i_hs_mode(i_hs_mode),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_type(i_req_type),
    .i_req_index(i_req_index), .i_req_wlength(i_req_wlength), .i_abort(i_abort),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_done(o_done), .o_stall(o_stall));

  usb_desc_server #(.NUM_EP(3), .EP_DIR_MASK(4'b0101), .HSSUPPORT(1'b0)) dut_fs (
    .CLK(CLK), .RESET(RESET), .i_vid(i_vid), .i_pid(i_pid), .i_hs_mode(i_hs_mode),
    .i_req_valid(i_req_valid), .o_req_ready(r1), .i_req_type(i_req_type),
    .i_req_index(i_req_index), .i_req_wlength(i_req_wlength), .i_abort(i_abort),
    .o_data(d1), .o_valid(v1), .i_ready(i_ready), .o_last(l1),
    .o_done(dn1), .o_stall(st1));

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Descriptor content for NUM_EP=3, EP_DIR_MASK=0101, HS supported, default strings/IDs.
  task automatic build(input logic [7:0] t, input logic [7:0] idx, input bit hs,
                       input logic [15:0] vid, input logic [15:0] pid, output bit st);
    logic [15:0] ev, epid;
    logic [7:0] dv[18], hd[18], qv[10], bv[12], lv[4], epd[7];
    logic [3:0] mask;
    string s;
    bit ehs;
    mask = 4'b0101;
    ev   = (vid == 16'h0000 || vid == 16'hFFFF) ? 16'h33AA : vid;
    epid = (pid == 16'h0000 || pid == 16'hFFFF) ? 16'h0000 : pid;
    desc.delete();
    st = 0;
    case (t)
      8'd1: if (idx != 0) st = 1; else begin
        dv = '{8'h12, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h40, ev[7:0], ev[15:8],
               epid[7:0], epid[15:8], 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
        foreach (dv[i]) desc.push_back(dv[i]);
      end
      8'd2, 8'd7: if (idx != 0) st = 1; else begin
        ehs = (t == 8'd7) ? !hs : hs;
        hd = '{8'h09, t, 8'd39, 8'h00, 8'h01, 8'h01, 8'h00, 8'hC0, 8'h32,
               8'h09, 8'h04, 8'h00, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        foreach (hd[i]) desc.push_back(hd[i]);
        for (int k = 1; k <= 3; k++) begin
          epd = '{8'h07, 8'h05, (mask[k-1] ? 8'h80 : 8'h00) | 8'(k), 8'h02,
                  ehs ? 8'h00 : 8'h40, ehs ? 8'h02 : 8'h00, 8'h00};
          foreach (epd[i]) desc.push_back(epd[i]);
        end
      end
      8'd6: if (idx != 0) st = 1; else begin
        qv = '{8'h0A, 8'h06, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h01, 8'h00};
        foreach (qv[i]) desc.push_back(qv[i]);
      end
      8'd15: if (idx != 0) st = 1; else begin
        bv = '{8'h05, 8'h0F, 8'h0C, 8'h00, 8'h01, 8'h07, 8'h10, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
        foreach (bv[i]) desc.push_back(bv[i]);
      end
      8'd3: if (idx == 0) begin
        lv = '{8'h04, 8'h03, 8'h09, 8'h04};
        foreach (lv[i]) desc.push_back(lv[i]);
      end else if (idx > 3) st = 1; else begin
        s = idx == 1 ? "OV5640 Camera" : idx == 2 ? "Video Streamer" : "12345678";
        desc.push_back(8'(2 + 2 * s.len()));
        desc.push_back(8'h03);
        for (int i = 0; i < s.len(); i++) begin
          desc.push_back(s[i]);
          desc.push_back(8'h00);
        end
      end
      default: st = 1;
    endcase
  endtask

  // Stream checker: every accepted byte must be the next expected one; stalled bytes must hold.
  always @(negedge CLK) if (!RESET) begin
    if (o_done) done_cnt++;
    if (o_stall) stall_cnt++;
    if (st1) stall1_cnt++;
    if (v1) v1_seen = 1;
    chk("last_without_valid", {31'd0, o_last & !o_valid}, 0);
    if (held_v) begin
      chk("hold_valid", {31'd0, o_valid}, 1);
      chk("hold_data", {24'd0, o_data}, {24'd0, held_d});
      chk("hold_last", {31'd0, o_last}, {31'd0, held_l});
    end
    held_v = o_valid && !i_ready && !i_abort;
    held_d = o_data;
    held_l = o_last;
    if (o_valid && i_ready && !i_abort) begin
      chk("byte_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_byte", {24'd0, o_data}, {24'd0, e});
        chk("stream_last", {31'd0, o_last}, {31'd0, exp_q.size() == 0});
      end
      rx.push_back(o_data);
    end
  end

  initial forever begin
    @(posedge CLK);
    #1 i_ready = hold_rdy ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] wl,
                       input logic [15:0] vid, input logic [15:0] pid, input bit hs);
    int n;
    build(t, idx, hs, vid, pid, exp_st);
    n = wl < desc.size() ? int'(wl) : desc.size();
    exp_q.delete();
    if (!exp_st) for (int i = 0; i < n; i++) exp_q.push_back(desc[i]);
    rx.delete();
    i_req_type = t; i_req_index = idx; i_req_wlength = wl;
    i_vid = vid; i_pid = pid; i_hs_mode = hs;
    i_req_valid = 1;
    @(posedge CLK); #1 i_req_valid = 0;
  endtask

  task automatic req(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] wl,
                     input logic [15:0] vid, input logic [15:0] pid, input bit hs, input bit rnd);
    int d0, s0, n;
    d0 = done_cnt; s0 = stall_cnt; rnd_ready = rnd;
    start(t, idx, wl, vid, pid, hs);
    n = 0;
    while (done_cnt == d0 && stall_cnt == s0 && n < 3000) begin
      @(posedge CLK); #1 n++;
    end
    chk("req_timeout", {31'd0, n < 3000}, 1);
    repeat (2) @(posedge CLK);
    #1;
    chk("done_pulses", done_cnt - d0, exp_st ? 0 : 1);
    chk("stall_pulses", stall_cnt - s0, exp_st ? 1 : 0);
    chk("bytes_left", exp_q.size(), 0);
    chk("ready_idle", {31'd0, o_req_ready}, 1);
    rnd_ready = 0;
  endtask

  initial begin
    int d0, s0, s1, n;
    @(posedge CLK); #1;
    chk("rst_req_ready", {31'd0, o_req_ready}, 1);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_last", {31'd0, o_last}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_stall", {31'd0, o_stall}, 0);
    chk("rst_data", {24'd0, o_data}, 0);
    RESET = 0;
    repeat (2) @(posedge CLK);
    #1;
    req(8'd1, 8'd0, 16'hFFFF, 16'h1234, 16'h5678, 1, 0);
    chk("dev_len", rx.size(), 18);
    chk("dev_vid_pid", {rx[8], rx[9], rx[10], rx[11]}, 32'h34127856);
    req(8'd1, 8'd0, 16'd8, 16'hFFFF, 16'h0000, 1, 0);
    chk("dev8_len", rx.size(), 8);
    chk("dev8_lo", {rx[0], rx[1], rx[2], rx[3]}, 32'h12010002);
    chk("dev8_hi", {rx[4], rx[5], rx[6], rx[7]}, 32'hFFFFFF40);
    req(8'd1, 8'd0, 16'd0, 16'h0000, 16'h0000, 1, 0);
    chk("wlen0_len", rx.size(), 0);
    req(8'd2, 8'd0, 16'd64, 16'h0000, 16'h0000, 1, 0);
    chk("cfg_len", rx.size(), 39);
    chk("cfg_type_total", {rx[1], rx[2], rx[3]}, 32'h022700);
    chk("cfg_addrs", {rx[20], rx[27], rx[34]}, 32'h810283);
    chk("cfg_mps", {rx[22], rx[23], rx[36], rx[37]}, 32'h00020002);
    s1 = stall1_cnt; v1_seen = 0;
    req(8'd7, 8'd0, 16'd64, 16'h0000, 16'h0000, 1, 0);
    chk("osc_len", rx.size(), 39);
    chk("osc_type", rx[1], 8'h07);
    chk("osc_mps", {rx[22], rx[23], rx[29], rx[30]}, 32'h40004000);
    chk("nohs_stall", stall1_cnt - s1, 1);
    chk("nohs_no_bytes", {31'd0, v1_seen}, 0);
    req(8'd2, 8'd0, 16'd20, 16'h0000, 16'h0000, 0, 1);
    chk("cfg_trunc_len", rx.size(), 20);
    req(8'd6, 8'd0, 16'd64, 16'h0000, 16'h0000, 1, 0);
    req(8'd3, 8'd0, 16'd255, 16'h0000, 16'h0000, 1, 0);
    chk("lang", {rx[0], rx[1], rx[2], rx[3]}, 32'h04030904);
    req(8'd3, 8'd2, 16'd255, 16'h0000, 16'h0000, 1, 1);
    chk("str_len", rx.size(), 30);
    chk("str_head", {rx[0], rx[1], rx[2], rx[3]}, 32'h1E035600);
    chk("str_i", {rx[4], rx[5]}, 32'h6900);
    req(8'd3, 8'd3, 16'd255, 16'h0000, 16'h0000, 1, 1);
    req(8'd3, 8'd4, 16'd255, 16'h0000, 16'h0000, 1, 0);
    req(8'd1, 8'd1, 16'd255, 16'h0000, 16'h0000, 1, 0);
    req(8'd9, 8'd0, 16'd255, 16'h0000, 16'h0000, 1, 0);
    // abort in the middle of a BOS stream
    d0 = done_cnt;
    start(8'd15, 8'd0, 16'd255, 16'h0000, 16'h0000, 1);
    n = 0;
    while (rx.size() != 5 && n < 50) begin
      @(posedge CLK); #2 n++;
    end
    chk("abort_reach_byte5", rx.size(), 5);
    hold_rdy = 1; i_ready = 0; i_abort = 1;
    @(posedge CLK); #2 i_abort = 0;
    chk("abort_valid", {31'd0, o_valid}, 0);
    chk("abort_last", {31'd0, o_last}, 0);
    exp_q.delete();
    repeat (4) @(posedge CLK);
    #2;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_ready", {31'd0, o_req_ready}, 1);
    hold_rdy = 0;
    @(posedge CLK); #1;
    req(8'd15, 8'd0, 16'd255, 16'h0000, 16'h0000, 1, 0);
    chk("bos_len", rx.size(), 12);
    chk("bos_head", {rx[0], rx[1], rx[2], rx[3]}, 32'h050F0C00);
    chk("bos_cap", rx[4], 8'h01);
    // abort beats a simultaneous request
    d0 = done_cnt; s0 = stall_cnt;
    exp_q.delete(); rx.delete();
    i_req_type = 8'd1; i_req_index = 8'd0; i_req_wlength = 16'd18;
    i_req_valid = 1; i_abort = 1;
    @(posedge CLK); #1 i_req_valid = 0; i_abort = 0;
    repeat (5) @(posedge CLK);
    #1;
    chk("abortreq_ready", {31'd0, o_req_ready}, 1);
    chk("abortreq_bytes", rx.size(), 0);
    chk("abortreq_pulses", (done_cnt - d0) + (stall_cnt - s0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
